// File: rtl/ascon_sbox_layer_folded.sv
// Folded Ascon substitution layer: LANES S-boxes sweep the 64 bit-slice
// columns of a 320-bit state over 64/LANES cycles behind valid/ready.
package ascon_pkg;
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;
endpackage

module ascon_sbox_layer_folded
  import ascon_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  ascon_state_t state_i,
  input  logic         valid_i,
  output logic         ready_o,
  output ascon_state_t state_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         busy_o
);

  localparam int NCHUNK = 64 / LANES;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 ||
        LANES == 16 || LANES == 32 || LANES == 64)) begin : g_bad_lanes
    $error("LANES must be one of 1,2,4,8,16,32,64");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_e;

  fsm_e         state_q, state_d;
  ascon_state_t work_q, work_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;
  logic          load;
  logic [5:0]    base;
  logic [5:0]    idx  [LANES];
  logic [4:0]    sb_o [LANES];

  function automatic logic [4:0] sbox(input logic [4:0] x);
    unique case (x)
      5'h00: return 5'h04;  5'h01: return 5'h0B;
      5'h02: return 5'h1F;  5'h03: return 5'h14;
      5'h04: return 5'h1A;  5'h05: return 5'h15;
      5'h06: return 5'h09;  5'h07: return 5'h02;
      5'h08: return 5'h1B;  5'h09: return 5'h05;
      5'h0A: return 5'h08;  5'h0B: return 5'h12;
      5'h0C: return 5'h1D;  5'h0D: return 5'h03;
      5'h0E: return 5'h06;  5'h0F: return 5'h1C;
      5'h10: return 5'h1E;  5'h11: return 5'h13;
      5'h12: return 5'h07;  5'h13: return 5'h0E;
      5'h14: return 5'h00;  5'h15: return 5'h0D;
      5'h16: return 5'h11;  5'h17: return 5'h18;
      5'h18: return 5'h10;  5'h19: return 5'h0C;
      5'h1A: return 5'h01;  5'h1B: return 5'h19;
      5'h1C: return 5'h16;  5'h1D: return 5'h0A;
      5'h1E: return 5'h0F;  5'h1F: return 5'h17;
      default: return 5'h00;
    endcase
  endfunction

  assign last = (cnt_q == CW'(NCHUNK - 1));
  assign load = valid_i & ready_o;
  assign base = 6'(cnt_q) * 6'(LANES);

  // Only the LANES columns of the current chunk go through an S-box.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign idx[l]  = base + 6'(l);
    assign sb_o[l] = sbox({work_q.x0[idx[l]], work_q.x1[idx[l]],
                           work_q.x2[idx[l]], work_q.x3[idx[l]],
                           work_q.x4[idx[l]]});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (valid_i) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (ready_i) state_d = valid_i ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    busy_o  = 1'b1;
    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
      end
      DONE: begin
        valid_o = 1'b1;
        ready_o = ready_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    if (state_q == BUSY) begin
      for (int l = 0; l < LANES; l++) begin
        work_d.x0[idx[l]] = sb_o[l][4];
        work_d.x1[idx[l]] = sb_o[l][3];
        work_d.x2[idx[l]] = sb_o[l][2];
        work_d.x3[idx[l]] = sb_o[l][1];
        work_d.x4[idx[l]] = sb_o[l][0];
      end
      if (!last) cnt_d = cnt_q + CW'(1);
    end else if (load) begin
      work_d = state_i;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      work_q <= '0;
      cnt_q  <= '0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
    end
  end

  assign state_o = work_q;

endmodule
